// File: rtl/divider_unit_pkg.sv
// Shared definitions for the restoring divider: state encoding, default widths
// and the fill value used to mark a divide-by-zero result.
package divider_unit_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide-by-zero reports all-ones in both quotient and remainder.
  localparam logic DBZ_FILL = 1'b1;
  localparam logic [DVD_W_DEF-1:0] DBZ_QUOT = {DVD_W_DEF{DBZ_FILL}};
  localparam logic [DVS_W_DEF-1:0] DBZ_REM  = {DVS_W_DEF{DBZ_FILL}};

endpackage

// File: rtl/divider_datapath.sv
// Operand/remainder/quotient registers, iteration counter and trial subtractor
// of the restoring divider, sequenced by load/clear/step strobes.
module divider_datapath
  import divider_unit_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             divisor_zero,
  output logic             last_step
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] dvs_reg;
  logic [DVS_W-1:0] rem_reg;
  logic [DVD_W-1:0] quot_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             dbz_reg;

  logic [DVS_W:0] trial;
  logic [DVS_W:0] dvs_ext;
  logic [DVS_W:0] diff;
  logic           fits;

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits are shifted in at the LSB.
  assign trial   = {rem_reg, quot_reg[DVD_W-1]};
  assign dvs_ext = {1'b0, dvs_reg};
  assign fits    = trial >= dvs_ext;
  assign diff    = trial - dvs_ext;

  assign divisor_zero = (divisor == '0);
  assign last_step    = (cnt_reg == CNT_W'(DVD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvs_reg  <= '0;
      rem_reg  <= '0;
      quot_reg <= '0;
      cnt_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      if (clear) begin
        rem_reg <= '0;
        cnt_reg <= '0;
        dbz_reg <= 1'b0;
      end
      if (load) begin
        dvs_reg <= divisor;
        if (divisor_zero) begin
          dbz_reg  <= 1'b1;
          quot_reg <= {DVD_W{DBZ_FILL}};
          rem_reg  <= {DVS_W{DBZ_FILL}};
        end else begin
          quot_reg <= dividend;
        end
      end else if (step) begin
        quot_reg <= {quot_reg[DVD_W-2:0], fits};
        rem_reg  <= fits ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: rtl/divider_unit.sv
// Sequential restoring divider with Start/Done/Ack handshake; one quotient bit
// per clock, control FSM here and arithmetic in divider_datapath.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic [DVD_W-1:0] Div_Dividend,
  input  logic [DVS_W-1:0] Div_Divisor,
  output logic [DVD_W-1:0] Div_Quotient,
  output logic [DVS_W-1:0] Div_Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  state_t state_reg;
  state_t state_next;
  logic   load;
  logic   clear;
  logic   step;
  logic   divisor_zero;
  logic   last_step;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    clear      = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          load       = 1'b1;
          clear      = 1'b1;
          state_next = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (Ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state_reg == CALC);
  assign Done = (state_reg == DONE);

  divider_datapath #(
    .DVD_W(DVD_W),
    .DVS_W(DVS_W)
  ) u_datapath (
    .clk         (Clock),
    .rst_n       (Reset),
    .load        (load),
    .clear       (clear),
    .step        (step),
    .dividend    (Div_Dividend),
    .divisor     (Div_Divisor),
    .quotient    (Div_Quotient),
    .remainder   (Div_Remainder),
    .div_by_zero (Div_By_Zero),
    .divisor_zero(divisor_zero),
    .last_step   (last_step)
  );

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: vector table plus scoreboard queue,
// with hand-written sequences for reset abort and handshake corner cases.
module tb_divider_unit;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] Div_Dividend;
  logic [3:0] Div_Divisor;
  logic [7:0] Div_Quotient;
  logic [3:0] Div_Remainder;
  logic       Busy;
  logic       Done;
  logic       Div_By_Zero;

  divider_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Ack          (Ack),
    .Div_Dividend (Div_Dividend),
    .Div_Divisor  (Div_Divisor),
    .Div_Quotient (Div_Quotient),
    .Div_Remainder(Div_Remainder),
    .Busy         (Busy),
    .Done         (Done),
    .Div_By_Zero  (Div_By_Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive operands and Start at a falling edge; record the expected result.
  task automatic start_op(input vec_t v);
    Div_Dividend = v.dvd;
    Div_Divisor  = v.dvs;
    Start        = 1'b1;
    sb.push_back(v);
  endtask

  // Count edges from the Start-sampling edge until Done, then score the result.
  task automatic wait_done(input int exp_lat, input bit hold_start,
                           input bit scramble, input bit ack_in_calc);
    vec_t e;
    int   cyc;
    @(negedge Clock);
    cyc = 1;
    if (!hold_start) Start = 1'b0;
    if (scramble) begin
      Div_Dividend = 8'($urandom);
      Div_Divisor  = 4'($urandom);
    end
    if (exp_lat > 1) check("busy_after_start", int'(Busy), 1);
    while (!Done && cyc < 40) begin
      if (ack_in_calc) Ack = (cyc == 3);
      @(negedge Clock);
      cyc++;
    end
    Ack = 1'b0;
    if (!Done) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    check("latency", cyc, exp_lat);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("quotient", int'(Div_Quotient), int'(e.q));
    check("remainder", int'(Div_Remainder), int'(e.r));
    check("div_by_zero", int'(Div_By_Zero), int'(e.dbz));
    check("busy_in_done", int'(Busy), 0);
    $display("txn %0d: %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d", n_txn, e.dvd, e.dvs,
             Div_Quotient, Div_Remainder, Div_By_Zero, cyc);
    n_txn++;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(negedge Clock);
    Ack = 1'b0;
    check("done_after_ack", int'(Done), 0);
    check("busy_after_ack", int'(Busy), 0);
  endtask

  initial begin
    vec_t h;
    vecs[0] = '{dvd: 8'd200, dvs: 4'd7,  q: 8'd28,  r: 4'd4,  dbz: 1'b0};
    vecs[1] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0,  dbz: 1'b0};
    vecs[2] = '{dvd: 8'd13,  dvs: 4'd15, q: 8'd0,   r: 4'd13, dbz: 1'b0};
    vecs[3] = '{dvd: 8'd0,   dvs: 4'd9,  q: 8'd0,   r: 4'd0,  dbz: 1'b0};
    vecs[4] = '{dvd: 8'd255, dvs: 4'd15, q: 8'd17,  r: 4'd0,  dbz: 1'b0};
    vecs[5] = '{dvd: 8'd42,  dvs: 4'd0,  q: 8'hFF,  r: 4'hF,  dbz: 1'b1};
    vecs[6] = '{dvd: 8'd100, dvs: 4'd3,  q: 8'd33,  r: 4'd1,  dbz: 1'b0};
    vecs[7] = '{dvd: 8'd9,   dvs: 4'd4,  q: 8'd2,   r: 4'd1,  dbz: 1'b0};

    Reset = 1'b0; Start = 1'b0; Ack = 1'b0;
    Div_Dividend = '0; Div_Divisor = '0;
    repeat (2) @(negedge Clock);
    check("reset_quotient", int'(Div_Quotient), 0);
    check("reset_remainder", int'(Div_Remainder), 0);
    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    check("reset_dbz", int'(Div_By_Zero), 0);
    Reset = 1'b1;
    @(negedge Clock);

    // Table: vector 1 scrambles operands after Start, vector 2 pulses Ack in CALC.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i]);
      wait_done(vecs[i].dbz ? 1 : 9, 1'b0, i == 1, i == 2);
      do_ack();
    end

    // Start held high: exactly one result, Done held without Ack.
    h = '{dvd: 8'd77, dvs: 4'd5, q: 8'd15, r: 4'd2, dbz: 1'b0};
    start_op(h);
    wait_done(9, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      check("hold_done", int'(Done), 1);
      check("hold_quotient", int'(Div_Quotient), 15);
      check("hold_remainder", int'(Div_Remainder), 2);
    end
    // Ack and Start together: Ack wins, the still-high Start launches the next run.
    h = '{dvd: 8'd50, dvs: 4'd6, q: 8'd8, r: 4'd2, dbz: 1'b0};
    Div_Dividend = h.dvd;
    Div_Divisor  = h.dvs;
    do_ack();
    start_op(h);
    wait_done(9, 1'b0, 1'b0, 1'b0);
    do_ack();

    // Asynchronous reset in the middle of CALC clears outputs without a clock edge.
    h = '{dvd: 8'd200, dvs: 4'd7, q: 8'd28, r: 4'd4, dbz: 1'b0};
    start_op(h);
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    check("pre_reset_busy", int'(Busy), 1);
    #1;
    Reset = 1'b0;
    #1;
    check("abort_busy", int'(Busy), 0);
    check("abort_done", int'(Done), 0);
    check("abort_quotient", int'(Div_Quotient), 0);
    check("abort_remainder", int'(Div_Remainder), 0);
    sb.delete();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    start_op(h);
    wait_done(9, 1'b0, 1'b0, 1'b0);
    do_ack();

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
